// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and constants for the MM:SS countdown timer
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_ALARM = 2'd3
   } state_t;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t min10;
      bcd_t min1;
      bcd_t sec10;
      bcd_t sec1;
   } mmss_t;

   localparam int SEC_MAX = 59;

endpackage

// File: rtl/mmss_countdown_timer_if.sv
// rtl/mmss_countdown_timer_if.sv - button pulses and display/status bundle of the timer
interface mmss_countdown_timer_if;

   logic        start_stop;
   logic        inc_sec;
   logic        inc_min;
   logic        clear;
   logic        alarm_off;
   logic [15:0] value;
   logic        running;
   logic        paused;
   logic        alarm;

   modport master (
      output start_stop, inc_sec, inc_min, clear, alarm_off,
      input  value, running, paused, alarm
   );

   modport slave (
      input  start_stop, inc_sec, inc_min, clear, alarm_off,
      output value, running, paused, alarm
   );

endinterface

// File: rtl/bcd_mmss_counter.sv
// rtl/bcd_mmss_counter.sv - loadable up/down MM:SS BCD counter with zero flag
module bcd_mmss_counter
   import timer_pkg::*;
#(
   parameter int MAX_MIN = 59
)(
   input  logic  clk,
   input  logic  reset_p,
   input  logic  clr,
   input  logic  load,
   input  mmss_t load_value,
   input  logic  inc_sec,
   input  logic  inc_min,
   input  logic  dec,
   output mmss_t count,
   output logic  is_zero
);

   localparam bcd_t MAX_M10 = bcd_t'(MAX_MIN / 10);
   localparam bcd_t MAX_M1  = bcd_t'(MAX_MIN % 10);
   localparam bcd_t SEC_M10 = bcd_t'(SEC_MAX / 10);
   localparam bcd_t SEC_M1  = bcd_t'(SEC_MAX % 10);

   mmss_t next;

   assign is_zero = (count == '0);

   // Next count: decrement with seconds borrow (held at zero), or independent sec/min wrap-around steps
   always_comb begin
      next = count;
      if (dec) begin
         if (!is_zero) begin
            if (count.sec1 != 4'd0) begin
               next.sec1 = count.sec1 - 4'd1;
            end else if (count.sec10 != 4'd0) begin
               next.sec10 = count.sec10 - 4'd1;
               next.sec1  = 4'd9;
            end else begin
               next.sec10 = SEC_M10;
               next.sec1  = SEC_M1;
               if (count.min1 != 4'd0) begin
                  next.min1 = count.min1 - 4'd1;
               end else begin
                  next.min1  = 4'd9;
                  next.min10 = count.min10 - 4'd1;
               end
            end
         end
      end else begin
         if (inc_sec) begin
            if (count.sec10 == SEC_M10 && count.sec1 == SEC_M1) begin
               next.sec10 = 4'd0;
               next.sec1  = 4'd0;
            end else if (count.sec1 == 4'd9) begin
               next.sec10 = count.sec10 + 4'd1;
               next.sec1  = 4'd0;
            end else begin
               next.sec1 = count.sec1 + 4'd1;
            end
         end
         if (inc_min) begin
            if (count.min10 == MAX_M10 && count.min1 == MAX_M1) begin
               next.min10 = 4'd0;
               next.min1  = 4'd0;
            end else if (count.min1 == 4'd9) begin
               next.min10 = count.min10 + 4'd1;
               next.min1  = 4'd0;
            end else begin
               next.min1 = count.min1 + 4'd1;
            end
         end
      end
   end

   // Count register: clear beats load beats step
   always_ff @(posedge clk) begin
      if (reset_p || clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else begin
         count <= next;
      end
   end

endmodule

// File: rtl/mmss_countdown_timer.sv
// rtl/mmss_countdown_timer.sv - MM:SS countdown timer top; MMSS_ALARM_AUTO_OFF_EN enables alarm auto-off
module mmss_countdown_timer
   import timer_pkg::*;
#(
   parameter int CLK_PER_SEC = 100_000_000,
   parameter int MAX_MIN     = 59
`ifdef MMSS_ALARM_AUTO_OFF_EN
   ,
   parameter int ALARM_SEC   = 10
`endif
)(
   input  logic                  clk,
   input  logic                  reset_p,
   mmss_countdown_timer_if.slave bus
);

   localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

   state_t        state;
   state_t        state_next;
   logic [PW-1:0] pre;
   logic          pre_en;
   logic          pre_clr;
   logic          tick;
   mmss_t         set_time;
   mmss_t         cur_time;
   logic          set_zero;
   logic          cur_zero;
   logic          cur_one;
   logic          cur_load;
   logic          cur_clr;
   logic          cur_dec;
   logic          set_inc_en;
   logic          alarm_expire;

   assign tick    = pre_en && (pre == PW'(CLK_PER_SEC - 1));
   assign cur_one = (cur_time == 16'h0001);

`ifdef MMSS_ALARM_AUTO_OFF_EN
   localparam int AW = $clog2(ALARM_SEC + 1);

   logic [AW-1:0] alarm_cnt;

   assign pre_en       = (state == ST_RUN) || (state == ST_ALARM);
   assign alarm_expire = tick && (state == ST_ALARM) && (alarm_cnt == AW'(ALARM_SEC - 1));

   // Seconds spent in ALARM, restarted whenever ALARM is not active
   always_ff @(posedge clk) begin
      if (reset_p || state != ST_ALARM) begin
         alarm_cnt <= '0;
      end else if (tick) begin
         alarm_cnt <= alarm_cnt + AW'(1);
      end
   end
`else
   assign pre_en       = (state == ST_RUN);
   assign alarm_expire = 1'b0;
`endif

   // One-second prescaler; frozen outside counting states so PAUSE resumes mid-second
   always_ff @(posedge clk) begin
      if (reset_p || pre_clr) begin
         pre <= '0;
      end else if (pre_en) begin
         pre <= tick ? '0 : pre + PW'(1);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset_p) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and counter controls; clear > start_stop > alarm_off > inc
   always_comb begin
      state_next = state;
      cur_load   = 1'b0;
      cur_clr    = 1'b0;
      cur_dec    = 1'b0;
      pre_clr    = 1'b0;
      set_inc_en = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.clear) begin
               cur_clr = 1'b1;
            end else if (bus.start_stop) begin
               if (!set_zero) begin
                  state_next = ST_RUN;
                  cur_load   = 1'b1;
                  pre_clr    = 1'b1;
               end
            end else if (!bus.alarm_off) begin
               set_inc_en = 1'b1;
            end
         end
         ST_RUN: begin
            if (bus.clear) begin
               state_next = ST_IDLE;
               cur_clr    = 1'b1;
            end else if (tick) begin
               // decrement first; reaching zero swallows a simultaneous pause
               cur_dec = !cur_zero;
               if (cur_one) begin
                  state_next = ST_ALARM;
               end else if (bus.start_stop) begin
                  state_next = ST_PAUSE;
               end
            end else if (bus.start_stop) begin
               state_next = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (bus.clear) begin
               state_next = ST_IDLE;
               cur_clr    = 1'b1;
            end else if (bus.start_stop) begin
               state_next = ST_RUN;
            end
         end
         ST_ALARM: begin
            if (bus.clear) begin
               state_next = ST_IDLE;
               cur_clr    = 1'b1;
            end else if (bus.start_stop || bus.alarm_off || alarm_expire) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   bcd_mmss_counter #(.MAX_MIN(MAX_MIN)) u_set_time (
      .clk        (clk),
      .reset_p    (reset_p),
      .clr        (1'b0),
      .load       (1'b0),
      .load_value ('0),
      .inc_sec    (set_inc_en && bus.inc_sec),
      .inc_min    (set_inc_en && bus.inc_min),
      .dec        (1'b0),
      .count      (set_time),
      .is_zero    (set_zero)
   );

   bcd_mmss_counter #(.MAX_MIN(MAX_MIN)) u_cur_time (
      .clk        (clk),
      .reset_p    (reset_p),
      .clr        (cur_clr),
      .load       (cur_load),
      .load_value (set_time),
      .inc_sec    (1'b0),
      .inc_min    (1'b0),
      .dec        (cur_dec),
      .count      (cur_time),
      .is_zero    (cur_zero)
   );

   assign bus.value   = (state == ST_IDLE) ? set_time : cur_time;
   assign bus.running = (state == ST_RUN);
   assign bus.paused  = (state == ST_PAUSE);
   assign bus.alarm   = (state == ST_ALARM);

endmodule

// File: tb/tb_mmss_countdown_timer.sv
// tb/tb_mmss_countdown_timer.sv - scoreboard bench for mmss_countdown_timer (CLK_PER_SEC=4, MAX_MIN=59)
module tb_mmss_countdown_timer;

   typedef struct {
      int          at;
      logic [15:0] value;
      logic        running;
      logic        paused;
      logic        alarm;
      string       name;
   } exp_t;

   logic clk;
   logic reset_p;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t sb[$];

   mmss_countdown_timer_if bus_if ();

   mmss_countdown_timer #(
      .CLK_PER_SEC (4),
      .MAX_MIN     (59)
`ifdef MMSS_ALARM_AUTO_OFF_EN
      ,
      .ALARM_SEC   (2)
`endif
   ) dut (
      .clk     (clk),
      .reset_p (reset_p),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation due at this cycle, shortly after the edge
   always begin
      @(posedge clk);
      #2;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         n_tests++;
         if (e.at != cyc) begin
            n_fail++;
            $display("FAIL %s: checked at cycle %0d, required at cycle %0d", e.name, cyc, e.at);
         end else if ({bus_if.value, bus_if.running, bus_if.paused, bus_if.alarm} !==
                      {e.value, e.running, e.paused, e.alarm}) begin
            n_fail++;
            $display("FAIL %s: got value=%h run=%b pause=%b alarm=%b, expected value=%h run=%b pause=%b alarm=%b",
                     e.name, bus_if.value, bus_if.running, bus_if.paused, bus_if.alarm,
                     e.value, e.running, e.paused, e.alarm);
         end
      end
   end

   task automatic expect_out(input int dly, input logic [15:0] v, input logic r,
                             input logic p, input logic a, input string nm);
      exp_t e;
      int   i;
      e.at = cyc + dly;
      e.value = v;
      e.running = r;
      e.paused = p;
      e.alarm = a;
      e.name = nm;
      i = 0;
      while (i < sb.size() && sb[i].at <= e.at) i++;
      sb.insert(i, e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic ss, input logic isec, input logic imin,
                        input logic cl, input logic ao);
      bus_if.start_stop = ss;
      bus_if.inc_sec    = isec;
      bus_if.inc_min    = imin;
      bus_if.clear      = cl;
      bus_if.alarm_off  = ao;
      @(negedge clk);
      bus_if.start_stop = 1'b0;
      bus_if.inc_sec    = 1'b0;
      bus_if.inc_min    = 1'b0;
      bus_if.clear      = 1'b0;
      bus_if.alarm_off  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_p = 1'b1;
      bus_if.start_stop = 1'b0;
      bus_if.inc_sec    = 1'b0;
      bus_if.inc_min    = 1'b0;
      bus_if.clear      = 1'b0;
      bus_if.alarm_off  = 1'b0;
      step(2);
      expect_out(1, 16'h0000, 0, 0, 0, "reset");
      step(1);
      reset_p = 1'b0;

      // Setting: minutes, seconds wrap without carry, minute wrap at MAX_MIN
      expect_out(3, 16'h0300, 0, 0, 0, "set_min3");
      for (int i = 0; i < 3; i++) press(0, 0, 1, 0, 0);
      expect_out(60, 16'h0300, 0, 0, 0, "sec_wrap");
      for (int i = 0; i < 60; i++) press(0, 1, 0, 0, 0);
      expect_out(1, 16'h0301, 0, 0, 0, "set_0301");
      press(0, 1, 0, 0, 0);
      expect_out(56, 16'h5901, 0, 0, 0, "min_max");
      for (int i = 0; i < 56; i++) press(0, 0, 1, 0, 0);
      expect_out(1, 16'h0001, 0, 0, 0, "min_wrap");
      press(0, 0, 1, 0, 0);
      expect_out(1, 16'h0101, 0, 0, 0, "set_0101");
      press(0, 0, 1, 0, 0);

      // Countdown 01:01 with borrow, alarm after 61 seconds
      expect_out(1,   16'h0101, 1, 0, 0, "start_0101");
      expect_out(5,   16'h0100, 1, 0, 0, "first_tick");
      expect_out(9,   16'h0059, 1, 0, 0, "borrow");
      expect_out(244, 16'h0001, 1, 0, 0, "before_zero");
      expect_out(245, 16'h0000, 0, 0, 1, "alarm_rise");
      press(1, 0, 0, 0, 0);
      step(244);
`ifdef MMSS_ALARM_AUTO_OFF_EN
      expect_out(7, 16'h0000, 0, 0, 1, "alarm_last");
      expect_out(8, 16'h0101, 0, 0, 0, "alarm_auto_off");
      step(8);
`else
      expect_out(100, 16'h0000, 0, 0, 1, "alarm_hold");
      step(100);
      expect_out(1, 16'h0101, 0, 0, 0, "alarm_off_exit");
      press(0, 0, 0, 0, 1);
`endif

      // Pause/resume at 00:05, then tick + start_stop at 00:01
      expect_out(63, 16'h0005, 0, 0, 0, "set_0005");
      for (int i = 0; i < 59; i++) press(0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) press(0, 1, 0, 0, 0);
      expect_out(1, 16'h0005, 1, 0, 0, "start_0005");
      press(1, 0, 0, 0, 0);
      step(1);
      expect_out(1, 16'h0005, 0, 1, 0, "pause");
      press(1, 0, 0, 0, 0);
      expect_out(20, 16'h0005, 0, 1, 0, "pause_hold");
      step(20);
      expect_out(1, 16'h0005, 1, 0, 0, "resume");
      expect_out(2, 16'h0005, 1, 0, 0, "resume_no_early_tick");
      expect_out(3, 16'h0004, 1, 0, 0, "resume_tick");
      press(1, 0, 0, 0, 0);
      step(16);
      expect_out(1, 16'h0001, 1, 0, 0, "at_0001");
      step(1);
      expect_out(1, 16'h0000, 0, 0, 1, "tick_ss_alarm");
      press(1, 0, 0, 0, 0);
      expect_out(1, 16'h0005, 0, 0, 0, "ss_exit_alarm");
      press(1, 0, 0, 0, 0);

      // Zero start ignored; inc in RUN ignored; clear+start_stop in PAUSE
      expect_out(55, 16'h0000, 0, 0, 0, "set_0000");
      for (int i = 0; i < 55; i++) press(0, 1, 0, 0, 0);
      expect_out(1, 16'h0000, 0, 0, 0, "zero_start");
      press(1, 0, 0, 0, 0);
      expect_out(2, 16'h0002, 0, 0, 0, "set_0002");
      for (int i = 0; i < 2; i++) press(0, 1, 0, 0, 0);
      expect_out(1, 16'h0002, 1, 0, 0, "start_0002");
      press(1, 0, 0, 0, 0);
      expect_out(1, 16'h0002, 1, 0, 0, "inc_in_run");
      press(0, 1, 0, 0, 0);
      expect_out(3, 16'h0001, 1, 0, 0, "tick_after_inc");
      step(3);
      expect_out(1, 16'h0001, 0, 1, 0, "pause_0001");
      press(1, 0, 0, 0, 0);
      expect_out(1, 16'h0002, 0, 0, 0, "clear_ss_pause");
      press(1, 0, 0, 1, 0);

      // Reset while in ALARM
      expect_out(1, 16'h0002, 1, 0, 0, "start_again");
      press(1, 0, 0, 0, 0);
      expect_out(8, 16'h0000, 0, 0, 1, "alarm_0002");
      step(8);
      expect_out(1, 16'h0000, 0, 0, 0, "reset_in_alarm");
      reset_p = 1'b1;
      step(1);
      reset_p = 1'b0;
      expect_out(1, 16'h0000, 0, 0, 0, "after_reset");
      step(1);

      for (int g = 0; g < 500 && sb.size() > 0; g++) step(1);
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL %s: never checked, required at cycle %0d", e.name, e.at);
      end
      step(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
